// File: rtl/block_drainer.sv
// block_drainer: captures a WORDS x WORD_WIDTH block in parallel and streams it out, word 0 first,
// over a valid/ready handshake. Define BLOCK_DRAINER_CHAIN_EN to accept a new block on the final-word transfer.
module block_drainer #(
  parameter int WORD_WIDTH = 64,
  parameter int WORDS      = 40
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load_L,
  input  logic [WORDS*WORD_WIDTH-1:0] in,
  output logic [WORD_WIDTH-1:0]       out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  word_idx,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun
);

  localparam int         BLOCK_WIDTH = WORDS * WORD_WIDTH;
  localparam logic [7:0] LAST_IDX    = 8'(WORDS - 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [BLOCK_WIDTH-1:0]  blk;
  logic [BLOCK_WIDTH-1:0]  blk_next;
  logic [WORD_WIDTH-1:0]   out_next;
  logic [7:0]              idx_next;
  logic                    done_next;
  logic                    overrun_next;
  logic                    load;
  logic                    xfer;
  logic                    last;
  logic                    chain_ok;

  // Word k sits at the top of the block for k = 0.
  function automatic logic [WORD_WIDTH-1:0] word_at(input logic [BLOCK_WIDTH-1:0] b,
                                                    input logic [7:0] k);
    word_at = b[(WORDS - 1 - int'(k)) * WORD_WIDTH +: WORD_WIDTH];
  endfunction

  assign load = ~load_L;
  assign xfer = (state == STREAM) & out_ready;
  assign last = (word_idx == LAST_IDX);

`ifdef BLOCK_DRAINER_CHAIN_EN
  assign chain_ok = xfer & last;
`else
  assign chain_ok = 1'b0;
`endif

  assign out_valid = (state == STREAM);
  assign busy      = (state == STREAM);

  // Next-state and next-datapath decode.
  always_comb begin
    state_next   = state;
    blk_next     = blk;
    out_next     = out;
    idx_next     = word_idx;
    done_next    = 1'b0;
    overrun_next = overrun;
    case (state)
      IDLE: begin
        if (load) begin
          state_next = STREAM;
          blk_next   = in;
          idx_next   = 8'd0;
          out_next   = word_at(in, 8'd0);
        end else begin
          state_next = IDLE;
        end
      end
      STREAM: begin
        if (xfer && last) begin
          state_next = IDLE;
          idx_next   = 8'd0;
          done_next  = 1'b1;
        end else if (xfer) begin
          idx_next = word_idx + 8'd1;
          out_next = word_at(blk, word_idx + 8'd1);
        end else begin
          state_next = STREAM;
        end
        // A load is only honoured mid-stream when it chains onto the final transfer.
        if (load && chain_ok) begin
          state_next = STREAM;
          blk_next   = in;
          idx_next   = 8'd0;
          out_next   = word_at(in, 8'd0);
        end else if (load) begin
          overrun_next = 1'b1;
        end else begin
          overrun_next = overrun;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      blk      <= '0;
      out      <= '0;
      word_idx <= 8'd0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      blk      <= blk_next;
      out      <= out_next;
      word_idx <= idx_next;
      done     <= done_next;
      overrun  <= overrun_next;
    end
  end

endmodule

// File: tb/tb_block_drainer.sv
// tb_block_drainer: table vectors, directed corner sequences and randomized traffic checked
// against a queue-based reference model of block_drainer.
module tb_block_drainer;
  localparam int W  = 64;
  localparam int N  = 40;
  localparam int BW = W * N;
  localparam logic [W-1:0] K1 = 64'h0101010101010101;
`ifdef BLOCK_DRAINER_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, load_L, out_ready;
  logic [BW-1:0] in;
  logic [W-1:0]  out;
  logic          out_valid, busy, done, overrun;
  logic [7:0]    word_idx;

  int total = 0;
  int bad   = 0;

  block_drainer #(.WORD_WIDTH(W), .WORDS(N)) dut (
    .clock(clock), .reset(reset), .load_L(load_L), .in(in), .out(out),
    .out_valid(out_valid), .out_ready(out_ready), .word_idx(word_idx),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of words still owed downstream.
  logic [W-1:0] q[$];
  logic [W-1:0] m_hold = '0;
  logic         m_done = 1'b0;
  logic         m_ovr  = 1'b0;

  logic [BW-1:0] blk_a, blk_b, blk_c;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [W-1:0] word_of(input logic [BW-1:0] b, input int k);
    return b[(N - 1 - k) * W +: W];
  endfunction

  task automatic model_step();
    bit was, xfer, fin;
    logic [W-1:0] w;
    if (reset) begin
      q.delete();
      m_hold = '0;
      m_done = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      was    = (q.size() != 0);
      xfer   = was && out_ready;
      fin    = 1'b0;
      m_done = 1'b0;
      if (xfer) begin
        w = q.pop_front();
        if (q.size() == 0) begin
          fin    = 1'b1;
          m_done = 1'b1;
          m_hold = w;
        end
      end
      if (!load_L) begin
        if (!was || (CHAIN && fin)) begin
          for (int k = 0; k < N; k++) q.push_back(word_of(in, k));
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
  endtask

  task automatic check_model();
    bit v;
    v = (q.size() != 0);
    check("m_valid",   out_valid, v);
    check("m_busy",    busy, v);
    check("m_idx",     word_idx, v ? 64'(N - q.size()) : 64'd0);
    check("m_out",     out, v ? q[0] : m_hold);
    check("m_done",    done, m_done);
    check("m_overrun", overrun, m_ovr);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1; load_L = 1'b1; out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_block(input logic [BW-1:0] b);
    in = b; load_L = 1'b0;
    tick();
    load_L = 1'b1;
  endtask

  typedef struct {
    logic rst, ld_n, rdy;
    logic ev, eb, ed, eo;
    logic [7:0] eidx;
    logic [W-1:0] eout;
  } vec_t;
  vec_t tbl[9];

  function automatic vec_t mk(input logic rst, ld_n, rdy, ev, ed, eo,
                              input int eidx, input logic [W-1:0] eout);
    vec_t v;
    v.rst = rst; v.ld_n = ld_n; v.rdy = rdy;
    v.ev = ev; v.eb = ev; v.ed = ed; v.eo = eo;
    v.eidx = 8'(eidx); v.eout = eout;
    return v;
  endfunction

  initial begin
    int c, vc, dc, xc;
    bit chained, xf;
    logic [W-1:0] w;
    logic [BW-1:0] filler;

    for (int k = 0; k < N; k++) blk_a[(N - 1 - k) * W +: W] = K1 * 64'(k);
    blk_b = rand_block();
    blk_c = rand_block();
    reset = 1'b0; load_L = 1'b1; out_ready = 1'b0; in = blk_a;

    // Table: one row per cycle, block A on in throughout.
    tbl[0] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
    tbl[1] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
    tbl[2] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, '0);
    tbl[3] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, '0);
    tbl[4] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, K1);
    tbl[5] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, K1 * 64'd2);
    tbl[6] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2, K1 * 64'd2);
    tbl[7] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3, K1 * 64'd3);
    tbl[8] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
    for (int i = 0; i < 9; i++) begin
      reset = tbl[i].rst; load_L = tbl[i].ld_n; out_ready = tbl[i].rdy;
      tick();
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      check($sformatf("tbl%0d_busy", i),  busy, tbl[i].eb);
      check($sformatf("tbl%0d_done", i),  done, tbl[i].ed);
      check($sformatf("tbl%0d_ovr", i),   overrun, tbl[i].eo);
      check($sformatf("tbl%0d_idx", i),   word_idx, tbl[i].eidx);
      check($sformatf("tbl%0d_out", i),   out, tbl[i].eout);
    end
    reset = 1'b0; load_L = 1'b1;

    // Full drain at one word per cycle.
    do_reset();
    out_ready = 1'b1;
    load_block(blk_a);
    check("drain_first_valid", out_valid, 1'b1);
    for (int k = 0; k < N; k++) begin
      check("drain_word", out, K1 * 64'(k));
      check("drain_idx", word_idx, 64'(k));
      check("drain_nodone", done, 1'b0);
      tick();
    end
    check("drain_done", done, 1'b1);
    check("drain_busy_low", busy, 1'b0);
    tick();
    check("drain_done_pulse", done, 1'b0);

    // Ready toggling 1,0: done lands in cycle 80 after the load.
    load_block(blk_a);
    c = 1;
    while (!done && c < 200) begin
      out_ready = c[0];
      tick();
      c++;
    end
    check("toggle_cycles", 64'(c), 64'd80);
    out_ready = 1'b1;

    // Load rejected mid-stream at word 5.
    do_reset();
    out_ready = 1'b1;
    load_block(blk_b);
    for (int i = 0; i < 5; i++) tick();
    check("ovr_at5", word_idx, 64'd5);
    in = blk_c; load_L = 1'b0;
    tick();
    load_L = 1'b1;
    check("ovr_set", overrun, 1'b1);
    check("ovr_keep_data", out, word_of(blk_b, 6));
    c = 0;
    while (!done && c < 100) begin tick(); c++; end
    for (int i = 0; i < 3; i++) tick();
    check("ovr_sticky", overrun, 1'b1);

    // Reset at word 20 abandons the block.
    do_reset();
    out_ready = 1'b1;
    load_block(blk_a);
    c = 0;
    while (word_idx != 8'd20 && c < 100) begin tick(); c++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst20_valid", out_valid, 1'b0);
    check("rst20_out", out, '0);
    check("rst20_idx", word_idx, 64'd0);
    check("rst20_done", done, 1'b0);
    tick();
    check("rst20_no_done", done, 1'b0);
    load_block(blk_b);
    check("rst20_reload", out, word_of(blk_b, 0));

    // Downstream shift-in filler rebuilds the block.
    do_reset();
    load_block(blk_b);
    filler = '0; xc = 0; c = 0;
    while (busy && c < 1000) begin
      out_ready = ($urandom_range(0, 2) != 0);
      #0;
      xf = out_valid && out_ready;
      w  = out;
      tick();
      if (xf) begin filler = {filler[BW-W-1:0], w}; xc++; end
      c++;
    end
    check("filler_xfers", 64'(xc), 64'(N));
    check("filler_match", 64'(filler == blk_b), 64'd1);

    // Second load timed on the final transfer.
    do_reset();
    out_ready = 1'b1;
    load_block(blk_a);
    vc = 0; dc = 0; chained = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) vc++;
      if (done) dc++;
      if (!chained && out_valid && word_idx == 8'(N - 1)) begin
        chained = 1'b1;
        in = blk_b; load_L = 1'b0;
      end
      tick();
      load_L = 1'b1;
    end
    check("chain_valid_cycles", 64'(vc), CHAIN ? 64'd80 : 64'd40);
    check("chain_dones", 64'(dc), CHAIN ? 64'd2 : 64'd1);
    check("chain_overrun", overrun, CHAIN ? 1'b0 : 1'b1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      load_L    = ($urandom_range(0, 9) != 0);
      reset     = ($urandom_range(0, 599) == 0);
      if (!load_L) in = rand_block();
      tick();
    end
    reset = 1'b0; load_L = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
